// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, feeds IF/ID.
// Ports: clk/Clear, Stall, BranchTaken/Target, imem req/addr/ready/rdata, IF_*.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        Clear,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [15:0] BranchTarget,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] IF_instr,
   output logic [15:0] IF_pc,
   output logic        IF_valid
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic [15:0] pc;
   logic [15:0] skid_instr;
   logic [15:0] skid_pc;
   logic [15:0] redir;
   logic [15:0] tgt;

   // instructions are halfword aligned
   assign tgt = BranchTarget & 16'hFFFE;

   assign imem_req  = ((state == FETCH) || (state == DRAIN)) && !Clear;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (Clear) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         IF_instr   <= 16'h0000;
         IF_pc      <= 16'h0000;
         IF_valid   <= 1'b0;
         skid_instr <= 16'h0000;
         skid_pc    <= 16'h0000;
         redir      <= 16'h0000;
      end else begin
         unique case (state)
            FETCH: begin
               if (BranchTaken) begin
                  IF_valid <= 1'b0;
                  if (imem_ready) begin
                     pc <= tgt;
                  end else begin
                     // request in flight: wait it out before retargeting
                     redir <= tgt;
                     state <= DRAIN;
                  end
               end else if (imem_ready) begin
                  if (Stall) begin
                     // capture the word now; the request is already done
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc;
                     state      <= HOLD;
                  end else begin
                     IF_instr <= imem_rdata;
                     IF_pc    <= pc;
                     IF_valid <= 1'b1;
                     pc       <= pc + PC_STEP;
                  end
               end else if (!Stall) begin
                  IF_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (BranchTaken) begin
                  pc       <= tgt;
                  IF_valid <= 1'b0;
                  state    <= FETCH;
               end else if (!Stall) begin
                  IF_instr <= skid_instr;
                  IF_pc    <= skid_pc;
                  IF_valid <= 1'b1;
                  pc       <= pc + PC_STEP;
                  state    <= FETCH;
               end
            end
            DRAIN: begin
               IF_valid <= 1'b0;
               if (BranchTaken) begin
                  redir <= tgt;
               end
               if (imem_ready) begin
                  // latest redirect wins, even on the completing cycle
                  pc    <= BranchTaken ? tgt : redir;
                  state <= FETCH;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory model returns addr ^ 16'hA5A5, or 16'hDEAD when poisoned.
module tb_fetch_stage;

   logic        clk;
   logic        Clear;
   logic        Stall;
   logic        BranchTaken;
   logic [15:0] BranchTarget;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] IF_instr;
   logic [15:0] IF_pc;
   logic        IF_valid;
   logic        poison;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk          (clk),
      .Clear        (Clear),
      .Stall        (Stall),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .IF_instr     (IF_instr),
      .IF_pc        (IF_pc),
      .IF_valid     (IF_valid)
   );

   assign imem_rdata = poison ? 16'hDEAD : (imem_addr ^ 16'hA5A5);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      Clear        = 1'b1;
      Stall        = 1'b0;
      BranchTaken  = 1'b0;
      BranchTarget = 16'h0000;
      imem_ready   = 1'b1;
      poison       = 1'b0;

      // T1 reset and streaming
      step();
      step();
      chk("rst_valid", {15'd0, IF_valid}, 16'd0);
      chk("rst_pc", IF_pc, 16'h0000);
      chk("rst_instr", IF_instr, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      Clear = 1'b0;
      #1;
      chk("t1_req", {15'd0, imem_req}, 16'd1);
      chk("t1_addr0", imem_addr, 16'h0000);
      step();
      chk("t1_pc0", IF_pc, 16'h0000);
      chk("t1_v0", {15'd0, IF_valid}, 16'd1);
      chk("t1_i0", IF_instr, 16'hA5A5);
      step();
      chk("t1_pc2", IF_pc, 16'h0002);
      step();
      chk("t1_pc4", IF_pc, 16'h0004);
      chk("t1_addr6", imem_addr, 16'h0006);

      // T3 stall with ready high at PC=0006
      Stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_hold_pc", IF_pc, 16'h0004);
         chk("t3_hold_req", {15'd0, imem_req}, 16'd0);
      end
      Stall = 1'b0;
      step();
      chk("t3_pc6", IF_pc, 16'h0006);
      chk("t3_i6", IF_instr, 16'hA5A3);
      chk("t3_v6", {15'd0, IF_valid}, 16'd1);
      step();
      chk("t3_pc8", IF_pc, 16'h0008);

      // T2 wait states: ready every third cycle
      for (int r = 0; r < 2; r++) begin
         imem_ready = 1'b0;
         step();
         chk("t2_v_a", {15'd0, IF_valid}, 16'd0);
         chk("t2_addr_a", imem_addr, 16'h000A + 16'(2 * r));
         step();
         chk("t2_v_b", {15'd0, IF_valid}, 16'd0);
         chk("t2_addr_b", imem_addr, 16'h000A + 16'(2 * r));
         imem_ready = 1'b1;
         step();
         chk("t2_v_c", {15'd0, IF_valid}, 16'd1);
         chk("t2_pc_c", IF_pc, 16'h000A + 16'(2 * r));
      end

      // T4 redirect with ready high (PC=000E)
      BranchTaken  = 1'b1;
      BranchTarget = 16'h0041;
      step();
      chk("t4_flush_v", {15'd0, IF_valid}, 16'd0);
      chk("t4_addr", imem_addr, 16'h0040);
      BranchTaken = 1'b0;
      step();
      chk("t4_pc40", IF_pc, 16'h0040);
      chk("t4_i40", IF_instr, 16'hA5E5);

      // T4 redirect into DRAIN (PC=0042)
      BranchTaken  = 1'b1;
      BranchTarget = 16'h0100;
      imem_ready   = 1'b0;
      step();
      chk("t4_dr_v", {15'd0, IF_valid}, 16'd0);
      chk("t4_dr_addr", imem_addr, 16'h0042);
      chk("t4_dr_req", {15'd0, imem_req}, 16'd1);
      BranchTaken = 1'b0;
      step();
      chk("t4_dr_addr2", imem_addr, 16'h0042);
      chk("t4_dr_v2", {15'd0, IF_valid}, 16'd0);
      imem_ready = 1'b1;
      poison     = 1'b1;
      step();
      chk("t4_dr_v3", {15'd0, IF_valid}, 16'd0);
      chk("t4_dr_instr", IF_instr, 16'hA5E5);
      chk("t4_dr_newaddr", imem_addr, 16'h0100);
      poison = 1'b0;
      step();
      chk("t4_pc100", IF_pc, 16'h0100);
      chk("t4_i100", IF_instr, 16'hA4A5);
      chk("t4_v100", {15'd0, IF_valid}, 16'd1);

      // T5 wrap
      BranchTaken  = 1'b1;
      BranchTarget = 16'hFFFE;
      step();
      chk("t5_addr_fffe", imem_addr, 16'hFFFE);
      BranchTaken = 1'b0;
      step();
      chk("t5_pc_fffe", IF_pc, 16'hFFFE);
      chk("t5_i_fffe", IF_instr, 16'h5A5B);
      chk("t5_wrap", imem_addr, 16'h0000);
      step();
      chk("t5_pc_0", IF_pc, 16'h0000);

      // T5 Stall and BranchTaken together: branch wins (PC=0002)
      Stall        = 1'b1;
      BranchTaken  = 1'b1;
      BranchTarget = 16'h0200;
      step();
      chk("t5_sb_req", {15'd0, imem_req}, 16'd1);
      chk("t5_sb_addr", imem_addr, 16'h0200);
      chk("t5_sb_v", {15'd0, IF_valid}, 16'd0);
      Stall       = 1'b0;
      BranchTaken = 1'b0;
      step();
      chk("t5_sb_pc", IF_pc, 16'h0200);
      chk("t5_sb_v2", {15'd0, IF_valid}, 16'd1);

      // T5 Clear during DRAIN (PC=0202)
      imem_ready   = 1'b0;
      BranchTaken  = 1'b1;
      BranchTarget = 16'h0300;
      step();
      chk("t5_cd_addr", imem_addr, 16'h0202);
      BranchTaken = 1'b0;
      Clear       = 1'b1;
      step();
      chk("t5_cd_v", {15'd0, IF_valid}, 16'd0);
      chk("t5_cd_req", {15'd0, imem_req}, 16'd0);
      chk("t5_cd_pc", IF_pc, 16'h0000);
      Clear      = 1'b0;
      imem_ready = 1'b1;
      #1;
      chk("t5_cd_addr0", imem_addr, 16'h0000);
      step();
      chk("t5_cd_ifpc", IF_pc, 16'h0000);
      chk("t5_cd_ifv", {15'd0, IF_valid}, 16'd1);
      chk("t5_cd_next", imem_addr, 16'h0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
